// File: rtl/f8_mem_pkg.sv
// Shared types and beat helpers for the f8 memory arbiter.
// Shared by the arbiter top and the read-data aligner.
package f8_mem_pkg;

    typedef enum logic [1:0] {IDLE, B0, B1, RESP} arb_state_t;
    typedef enum logic [1:0] {PORT_DW, PORT_DR, PORT_IF, PORT_DMA} arb_port_t;

    typedef struct packed {
        logic        en;
        logic [14:0] addr;
        logic [1:0]  we;
        logic [15:0] wdata;
    } mem_cmd_t;

    function automatic logic [1:0] beat_count(arb_port_t port, logic addr0, logic [1:0] dw_en);
        case (port)
            PORT_IF: beat_count = 2'd2;
            PORT_DR: beat_count = addr0 ? 2'd2 : 2'd1;
            // A write with no enabled lanes still takes one (empty) beat.
            PORT_DW: beat_count = (addr0 && dw_en != 2'b00) ? 2'd2 : 2'd1;
            default: beat_count = 2'd1;
        endcase
    endfunction

    // Memory command for one beat. DMA addresses arrive here as {word, 1'b0}.
    function automatic mem_cmd_t mem_beat(arb_port_t port, logic [15:0] addr, logic beat1,
                                          logic [15:0] data, logic [1:0] en);
        mem_cmd_t cmd;
        cmd.addr  = beat1 ? addr[15:1] + 15'd1 : addr[15:1];
        cmd.we    = 2'b00;
        cmd.wdata = 16'h0000;
        case (port)
            PORT_DW: begin
                if (!addr[0]) begin
                    cmd.we    = en;
                    cmd.wdata = data;
                end else begin
                    // Byte-swapped data serves both beats of an odd write.
                    cmd.we    = beat1 ? {1'b0, en[1]} : {en[0], 1'b0};
                    cmd.wdata = {data[7:0], data[15:8]};
                end
            end
            PORT_DMA: begin
                cmd.we    = en;
                cmd.wdata = data;
            end
            default: ;
        endcase
        cmd.en = (port != PORT_DW) || (cmd.we != 2'b00);
        return cmd;
    endfunction

endpackage

// File: rtl/f8_mem_arbiter_align.sv
// Little-endian reassembly of the beat read words into the requester's view.
module f8_rdata_align
    import f8_mem_pkg::*;
(
    input  arb_port_t   port,
    input  logic        addr0,
    input  logic [15:0] w0,
    input  logic [15:0] w1,
    output logic [23:0] data
);

    always_comb begin
        data = {8'h00, w0};
        case (port)
            PORT_IF: data = addr0 ? {w1, w0[15:8]} : {w1[7:0], w0};
            PORT_DR: if (addr0) data = {8'h00, w1[7:0], w0[15:8]};
            default: ;
        endcase
    end

endmodule

// File: rtl/f8_mem_arbiter.sv
// Arbitrates the f8 core's fetch/read/write ports and a DMA master onto one
// 16-bit byte-lane SRAM, splitting unaligned and 24-bit accesses into beats.
module f8_mem_arbiter
    import f8_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ready,
    output logic [23:0] if_data,
    input  logic        dr_req,
    input  logic [15:0] dr_addr,
    output logic        dr_ready,
    output logic [15:0] dr_data,
    input  logic        dw_req,
    input  logic [15:0] dw_addr,
    input  logic [15:0] dw_data,
    input  logic [1:0]  dw_en,
    output logic        dw_ready,
    input  logic        dma_req,
    input  logic [14:0] dma_addr,
    input  logic [1:0]  dma_we,
    input  logic [15:0] dma_wdata,
    output logic        dma_ready,
    output logic [15:0] dma_rdata,
    output logic        mem_en,
    output logic [14:0] mem_addr,
    output logic [1:0]  mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    arb_state_t    state;
    arb_port_t     owner;
    logic [15:0]   addr_q;
    logic [15:0]   data_q;
    logic [1:0]    en_q;
    logic          two_beat;
    logic [15:0]   w0_q;
    logic [CW-1:0] starve_cnt;
    logic [3:0]    ready_q;
    mem_cmd_t      mem_q;

    arb_port_t   sel_port;
    logic [15:0] sel_addr;
    logic [15:0] sel_data;
    logic [1:0]  sel_en;
    logic        any_req;
    logic [23:0] aligned;

    assign any_req = dw_req | dr_req | if_req | dma_req;

    always_comb begin
        sel_port = PORT_DMA;
        sel_addr = {dma_addr, 1'b0};
        sel_data = dma_wdata;
        sel_en   = dma_we;
        if (dma_req && starve_cnt == STARVE_MAX) begin
            sel_port = PORT_DMA;
        end else if (dw_req) begin
            sel_port = PORT_DW;
            sel_addr = dw_addr;
            sel_data = dw_data;
            sel_en   = dw_en;
        end else if (dr_req) begin
            sel_port = PORT_DR;
            sel_addr = dr_addr;
        end else if (if_req) begin
            sel_port = PORT_IF;
            sel_addr = if_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= PORT_DW;
            addr_q     <= '0;
            data_q     <= '0;
            en_q       <= '0;
            two_beat   <= 1'b0;
            w0_q       <= '0;
            starve_cnt <= '0;
            ready_q    <= '0;
            mem_q      <= '0;
        end else begin
            // NOTE: pulses and memory strobes default low each cycle; the case below only raises them.
            ready_q <= '0;
            mem_q   <= '0;
            case (state)
                IDLE: if (any_req) begin
                    owner    <= sel_port;
                    addr_q   <= sel_addr;
                    data_q   <= sel_data;
                    en_q     <= sel_en;
                    two_beat <= (beat_count(sel_port, sel_addr[0], sel_en) == 2'd2);
                    mem_q    <= mem_beat(sel_port, sel_addr, 1'b0, sel_data, sel_en);
                    state    <= B0;
                    if (sel_port == PORT_DMA)
                        starve_cnt <= '0;
                    else if (dma_req)
                        starve_cnt <= starve_cnt + CW'(1);
                end
                B0: if (two_beat) begin
                    mem_q <= mem_beat(owner, addr_q, 1'b1, data_q, en_q);
                    state <= B1;
                end else begin
                    ready_q[owner] <= 1'b1;
                    state          <= RESP;
                end
                B1: begin
                    w0_q           <= mem_rdata;
                    ready_q[owner] <= 1'b1;
                    state          <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The final beat's word is still on mem_rdata during RESP.
    f8_rdata_align u_align (
        .port  (owner),
        .addr0 (addr_q[0]),
        .w0    (two_beat ? w0_q : mem_rdata),
        .w1    (mem_rdata),
        .data  (aligned)
    );

    assign dw_ready  = ready_q[PORT_DW];
    assign dr_ready  = ready_q[PORT_DR];
    assign if_ready  = ready_q[PORT_IF];
    assign dma_ready = ready_q[PORT_DMA];
    assign if_data   = aligned;
    assign dr_data   = aligned[15:0];
    assign dma_rdata = aligned[15:0];
    assign mem_en    = mem_q.en;
    assign mem_addr  = mem_q.addr;
    assign mem_we    = mem_q.we;
    assign mem_wdata = mem_q.wdata;

endmodule
